vga_scan_timing: RTL and testbench

Scan-timing generator for the 800×600@72 Hz VGA output (pclk = 50 MHz). It produces the sync pulses driven to the connector and the `hen`/`ven` active-window flags consumed by the downstream display-data stage. That stage uses the flags to step its frame-buffer read address and gate `rgb`. Together the two form the display unit. Horizontal and vertical phase sequencers, frame/line markers and active-pixel coordinates are all generated here.

---
 rtl/vga_scan_timing.sv | 161 ++++++++++++++++
 tb/tb_vga_scan_timing.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timing.sv
// -----------------------------------------------------------------------------
// vga_scan_timing
//
// Scan-timing generator for an 800x600@72 Hz VGA raster (pclk = 50 MHz with
// the default parameters). A pixel counter (hcnt) and a line counter (vcnt)
// walk the raster. Two small phase sequencers track SYNC / BACK PORCH /
// ACTIVE / FRONT PORCH for each axis. Every output is registered from the
// *next* counter and phase values, so in any cycle each output is the decode
// of the hcnt/vcnt shown in that same cycle. There is no skew between the
// outputs.
//
// Ports
//   pclk        in   pixel clock
//   rstn        in   synchronous, active-low reset
//   hs, vs      out  sync pulses to the connector (polarity set by HSPOL/VSPOL)
//   hen, ven    out  horizontal / vertical active-window flags
//   hcnt        out  [10:0] pixel position in line, 0..HT-1
//   vcnt        out  [9:0]  line position in frame, 0..VT-1
//   px, py      out  active-area coordinates, 0 outside the active area
//   line_start  out  one-cycle pulse while hcnt==0
//   frame_start out  one-cycle pulse while hcnt==0 && vcnt==0
//   h_phase     out  [1:0] horizontal sequencer state (debug)
//   v_phase     out  [1:0] vertical sequencer state (debug)
//                    encoding: 0=SYNC, 1=BACK PORCH, 2=ACTIVE, 3=FRONT PORCH
//
// Reset loads the last position of the frame (hcnt=HT-1, vcnt=VT-1). The first
// edge after release therefore starts a fresh frame at (0,0).
// -----------------------------------------------------------------------------
module vga_scan_timing #(
  parameter int HSW   = 120,
  parameter int HBP   = 64,
  parameter int HEN   = 800,
  parameter int HFP   = 56,
  parameter int VSW   = 6,
  parameter int VBP   = 23,
  parameter int VEN   = 600,
  parameter int VFP   = 37,
  parameter bit HSPOL = 1'b1,
  parameter bit VSPOL = 1'b1
) (
  input  logic        pclk,
  input  logic        rstn,
  output logic        hs,
  output logic        vs,
  output logic        hen,
  output logic        ven,
  output logic [10:0] hcnt,
  output logic [9:0]  vcnt,
  output logic [10:0] px,
  output logic [9:0]  py,
  output logic        line_start,
  output logic        frame_start,
  output logic [1:0]  h_phase,
  output logic [1:0]  v_phase
);

  localparam int HT = HSW + HBP + HEN + HFP;
  localparam int VT = VSW + VBP + VEN + VFP;

  // Phase boundary positions on each axis.
  localparam logic [10:0] H_LAST   = 11'(HT - 1);
  localparam logic [10:0] H_BP_AT  = 11'(HSW);
  localparam logic [10:0] H_ACT_AT = 11'(HSW + HBP);
  localparam logic [10:0] H_FP_AT  = 11'(HSW + HBP + HEN);

  localparam logic [9:0]  V_LAST   = 10'(VT - 1);
  localparam logic [9:0]  V_BP_AT  = 10'(VSW);
  localparam logic [9:0]  V_ACT_AT = 10'(VSW + VBP);
  localparam logic [9:0]  V_FP_AT  = 10'(VSW + VBP + VEN);

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_t;

  phase_t      h_state, h_next;
  phase_t      v_state, v_next;
  logic [10:0] hcnt_next;
  logic [9:0]  vcnt_next;
  logic        h_wrap;
  logic        act_next;

  assign h_phase = h_state;
  assign v_phase = v_state;

  // Next raster position: the line counter steps on the same edge that
  // the pixel counter wraps.
  always_comb begin
    h_wrap    = (hcnt == H_LAST);
    hcnt_next = h_wrap ? 11'd0 : hcnt + 11'd1;
    vcnt_next = vcnt;
    if (h_wrap) begin
      vcnt_next = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end
  end

  // Phase sequencers. They change only when the next count lands on a phase
  // boundary, so each one stays equal to the decode of its counter. All
  // boundaries are distinct because every field is at least 1.
  always_comb begin
    h_next = h_state;
    if (hcnt_next == 11'd0)         h_next = PH_SYNC;
    else if (hcnt_next == H_BP_AT)  h_next = PH_BP;
    else if (hcnt_next == H_ACT_AT) h_next = PH_ACT;
    else if (hcnt_next == H_FP_AT)  h_next = PH_FP;

    v_next = v_state;
    if (h_wrap) begin
      if (vcnt_next == 10'd0)         v_next = PH_SYNC;
      else if (vcnt_next == V_BP_AT)  v_next = PH_BP;
      else if (vcnt_next == V_ACT_AT) v_next = PH_ACT;
      else if (vcnt_next == V_FP_AT)  v_next = PH_FP;
    end

    act_next = (h_next == PH_ACT) && (v_next == PH_ACT);
  end

  // Counter and sequencer state. HT-1 and VT-1 always fall in the front
  // porches, so reset loads both sequencers with FP.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      hcnt    <= H_LAST;
      vcnt    <= V_LAST;
      h_state <= PH_FP;
      v_state <= PH_FP;
    end else begin
      hcnt    <= hcnt_next;
      vcnt    <= vcnt_next;
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // Output registers, decoded from next-state values so they line up with
  // the counters above. vs follows v_next, which only moves while the pixel
  // counter wraps. As a result, vs only changes on the edge into hcnt==0.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      hs          <= ~HSPOL;
      vs          <= ~VSPOL;
      hen         <= 1'b0;
      ven         <= 1'b0;
      px          <= 11'd0;
      py          <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= (h_next == PH_SYNC) ? HSPOL : ~HSPOL;
      vs          <= (v_next == PH_SYNC) ? VSPOL : ~VSPOL;
      hen         <= (h_next == PH_ACT);
      ven         <= (v_next == PH_ACT);
      px          <= act_next ? (hcnt_next - H_ACT_AT) : 11'd0;
      py          <= act_next ? (vcnt_next - V_ACT_AT) : 10'd0;
      line_start  <= (hcnt_next == 11'd0);
      frame_start <= (hcnt_next == 11'd0) && (vcnt_next == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_timing
//
// Three instances share one clock and reset:
//   0: default 800x600 timing
//   1: tiny raster (8 pixels x 5 lines)
//   2: medium raster (19 x 12) with both sync polarities inverted
// A raster-position model per instance predicts every output from arithmetic
// on (h, v). The model is compared against the DUT on each negative edge.
// Literal checks pin reset values, line metrics and frame metrics.
// The only input is rstn, and it is pulsed at random points.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_scan_timing;

  localparam int P_HSW [3] = '{120, 2, 3};
  localparam int P_HBP [3] = '{64,  1, 4};
  localparam int P_HEN [3] = '{800, 4, 10};
  localparam int P_HFP [3] = '{56,  1, 2};
  localparam int P_VSW [3] = '{6,   1, 2};
  localparam int P_VBP [3] = '{23,  1, 3};
  localparam int P_VEN [3] = '{600, 2, 5};
  localparam int P_VFP [3] = '{37,  1, 2};
  localparam bit P_HSP [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit P_VSP [3] = '{1'b1, 1'b1, 1'b0};

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic rstn = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- DUT outputs ----------------
  logic [2:0]       hs_w, vs_w, hen_w, ven_w, ls_w, fs_w;
  logic [2:0][10:0] hc_w, px_w;
  logic [2:0][9:0]  vc_w, py_w;
  logic [2:0][1:0]  hp_w, vp_w;

  vga_scan_timing #(
    .HSW(P_HSW[0]), .HBP(P_HBP[0]), .HEN(P_HEN[0]), .HFP(P_HFP[0]),
    .VSW(P_VSW[0]), .VBP(P_VBP[0]), .VEN(P_VEN[0]), .VFP(P_VFP[0]),
    .HSPOL(P_HSP[0]), .VSPOL(P_VSP[0])
  ) u_def (
    .pclk(pclk), .rstn(rstn), .hs(hs_w[0]), .vs(vs_w[0]), .hen(hen_w[0]),
    .ven(ven_w[0]), .hcnt(hc_w[0]), .vcnt(vc_w[0]), .px(px_w[0]), .py(py_w[0]),
    .line_start(ls_w[0]), .frame_start(fs_w[0]), .h_phase(hp_w[0]), .v_phase(vp_w[0])
  );

  vga_scan_timing #(
    .HSW(P_HSW[1]), .HBP(P_HBP[1]), .HEN(P_HEN[1]), .HFP(P_HFP[1]),
    .VSW(P_VSW[1]), .VBP(P_VBP[1]), .VEN(P_VEN[1]), .VFP(P_VFP[1]),
    .HSPOL(P_HSP[1]), .VSPOL(P_VSP[1])
  ) u_small (
    .pclk(pclk), .rstn(rstn), .hs(hs_w[1]), .vs(vs_w[1]), .hen(hen_w[1]),
    .ven(ven_w[1]), .hcnt(hc_w[1]), .vcnt(vc_w[1]), .px(px_w[1]), .py(py_w[1]),
    .line_start(ls_w[1]), .frame_start(fs_w[1]), .h_phase(hp_w[1]), .v_phase(vp_w[1])
  );

  vga_scan_timing #(
    .HSW(P_HSW[2]), .HBP(P_HBP[2]), .HEN(P_HEN[2]), .HFP(P_HFP[2]),
    .VSW(P_VSW[2]), .VBP(P_VBP[2]), .VEN(P_VEN[2]), .VFP(P_VFP[2]),
    .HSPOL(P_HSP[2]), .VSPOL(P_VSP[2])
  ) u_pol (
    .pclk(pclk), .rstn(rstn), .hs(hs_w[2]), .vs(vs_w[2]), .hen(hen_w[2]),
    .ven(ven_w[2]), .hcnt(hc_w[2]), .vcnt(vc_w[2]), .px(px_w[2]), .py(py_w[2]),
    .line_start(ls_w[2]), .frame_start(fs_w[2]), .h_phase(hp_w[2]), .v_phase(vp_w[2])
  );

  // ---------------- counts ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        hs, vs, hen, ven, ls, fs;
    logic [1:0]  hph, vph;
    logic [10:0] hc;
    logic [9:0]  vc;
    logic [10:0] px;
    logic [9:0]  py;
  } obs_t;

  function automatic int ht(input int k);
    return P_HSW[k] + P_HBP[k] + P_HEN[k] + P_HFP[k];
  endfunction

  function automatic int vt(input int k);
    return P_VSW[k] + P_VBP[k] + P_VEN[k] + P_VFP[k];
  endfunction

  // Phase index of a position on one axis: 0 sync, 1 bp, 2 active, 3 fp.
  function automatic logic [1:0] phase_of(input int pos, input int sw, input int bp, input int en);
    if (pos < sw)           return 2'd0;
    if (pos < sw + bp)      return 2'd1;
    if (pos < sw + bp + en) return 2'd2;
    return 2'd3;
  endfunction

  function automatic obs_t model_out(input int k, input int h, input int v, input bit in_reset);
    obs_t e;
    int   hx, vy;
    hx     = P_HSW[k] + P_HBP[k];
    vy     = P_VSW[k] + P_VBP[k];
    e.hc   = 11'(h);
    e.vc   = 10'(v);
    e.hph  = phase_of(h, P_HSW[k], P_HBP[k], P_HEN[k]);
    e.vph  = phase_of(v, P_VSW[k], P_VBP[k], P_VEN[k]);
    e.hs   = (h < P_HSW[k]) ? P_HSP[k] : !P_HSP[k];
    e.vs   = (v < P_VSW[k]) ? P_VSP[k] : !P_VSP[k];
    e.hen  = (h >= hx) && (h < hx + P_HEN[k]);
    e.ven  = (v >= vy) && (v < vy + P_VEN[k]);
    e.px   = (e.hen && e.ven) ? 11'(h - hx) : 11'd0;
    e.py   = (e.hen && e.ven) ? 10'(v - vy) : 10'd0;
    e.ls   = (h == 0);
    e.fs   = (h == 0) && (v == 0);
    // Reset forces vs inactive regardless of the line (it sits at VT-1 anyway).
    if (in_reset) e.vs = !P_VSP[k];
    return e;
  endfunction

  int mh [3];
  int mv [3];
  bit mrst;
  bit mvalid = 1'b0;

  always @(posedge pclk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        mh[k] <= ht(k) - 1;
        mv[k] <= vt(k) - 1;
      end else if (mh[k] == ht(k) - 1) begin
        mh[k] <= 0;
        mv[k] <= (mv[k] + 1) % vt(k);
      end else begin
        mh[k] <= mh[k] + 1;
      end
    end
    mrst <= !rstn;
    if (!rstn) mvalid <= 1'b1;
  end

  // Compare process: every instance, every cycle once the model is seeded.
  always @(negedge pclk) begin
    cyc <= cyc + 1;
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        obs_t e, g;
        e = model_out(k, mh[k], mv[k], mrst);
        g = '{hs: hs_w[k], vs: vs_w[k], hen: hen_w[k], ven: ven_w[k], ls: ls_w[k],
              fs: fs_w[k], hph: hp_w[k], vph: vp_w[k], hc: hc_w[k], vc: vc_w[k],
              px: px_w[k], py: py_w[k]};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL model_dut%0d cyc=%0d got hc=%0d vc=%0d hs=%b vs=%b hen=%b ven=%b px=%0d py=%0d ls=%b fs=%b ph=%0d/%0d expected hc=%0d vc=%0d hs=%b vs=%b hen=%b ven=%b px=%0d py=%0d ls=%b fs=%b ph=%0d/%0d",
                   k, cyc, g.hc, g.vc, g.hs, g.vs, g.hen, g.ven, g.px, g.py, g.ls, g.fs, g.hph, g.vph,
                   e.hc, e.vc, e.hs, e.vs, e.hen, e.ven, e.px, e.py, e.ls, e.fs, e.hph, e.vph);
        end
      end
    end
  end

  // ---------------- directed measurements + random resets ----------------
  initial begin : main
    int hs_hi, hen_hi, ls_n, ls_off, rise_n, rise_bad;
    int sm_fs, sm_fs_off, sm_ven_f0, pol_hs_lo, pol_vs_lo, pol_act_rise, pol_fs;
    int def_early_hen;
    logic [7:0] sm_hen, sm_hen_exp;
    logic       prev_hen, prev_act;

    rstn = 1'b0;
    repeat (5) @(posedge pclk);
    @(negedge pclk);

    // Reset state.
    chk("rst_hcnt",  32'(hc_w[0]), 32'd1039);
    chk("rst_vcnt",  32'(vc_w[0]), 32'd665);
    chk("rst_hs",    32'(hs_w[0]), 32'd0);
    chk("rst_vs",    32'(vs_w[0]), 32'd0);
    chk("rst_hen",   32'(hen_w[0]), 32'd0);
    chk("rst_ven",   32'(ven_w[0]), 32'd0);
    chk("rst_ls",    32'(ls_w[0]), 32'd0);
    chk("rst_fs",    32'(fs_w[0]), 32'd0);
    chk("rst_pol_hs", 32'(hs_w[2]), 32'd1);
    chk("rst_pol_vs", 32'(vs_w[2]), 32'd1);

    rstn = 1'b1;
    @(negedge pclk);

    // First edge after release.
    chk("first_hcnt", 32'(hc_w[0]), 32'd0);
    chk("first_vcnt", 32'(vc_w[0]), 32'd0);
    chk("first_ls",   32'(ls_w[0]), 32'd1);
    chk("first_fs",   32'(fs_w[0]), 32'd1);
    chk("first_hs",   32'(hs_w[0]), 32'd1);
    chk("first_vs",   32'(vs_w[0]), 32'd1);
    chk("first_pol_hs", 32'(hs_w[2]), 32'd0);
    chk("first_pol_vs", 32'(vs_w[2]), 32'd0);

    hs_hi = 0; hen_hi = 0; ls_n = 0; ls_off = 0; rise_n = 0; rise_bad = 0;
    sm_fs = 0; sm_fs_off = 0; sm_ven_f0 = 0; sm_hen = '0;
    pol_hs_lo = 0; pol_vs_lo = 0; pol_act_rise = 0; pol_fs = 0;
    prev_hen = 1'b0; prev_act = 1'b0;

    // Three default lines; the small and medium rasters run alongside.
    for (int c = 0; c < 3 * 1040; c++) begin
      if (hs_w[0]) hs_hi++;
      if (hen_w[0]) hen_hi++;
      if (ls_w[0]) begin
        ls_n++;
        if (c % 1040 != 0) ls_off++;
      end
      if (hen_w[0] && !prev_hen) begin
        rise_n++;
        if (hc_w[0] != 11'd184) rise_bad++;
      end
      prev_hen = hen_w[0];

      if (c < 8) sm_hen[c] = hen_w[1];
      if (c < 120 && fs_w[1]) begin
        sm_fs++;
        if (c % 40 != 0) sm_fs_off++;
      end
      if (c < 40 && ven_w[1] && (c >= 16) && (c < 32)) sm_ven_f0++;
      if (c < 40 && ven_w[1] && !((c >= 16) && (c < 32))) sm_ven_f0 += 100;

      if (c < 228) begin
        if (!hs_w[2]) pol_hs_lo++;
        if (!vs_w[2]) pol_vs_lo++;
        if (hen_w[2] && ven_w[2] && !prev_act) pol_act_rise++;
        prev_act = hen_w[2] && ven_w[2];
      end
      if (c <= 228 && fs_w[2]) pol_fs++;
      @(negedge pclk);
    end

    chk("line_hs_high",   32'(hs_hi),  32'd360);
    chk("line_hen_high",  32'(hen_hi), 32'd2400);
    chk("line_ls_count",  32'(ls_n),   32'd3);
    chk("line_ls_offpos", 32'(ls_off), 32'd0);
    chk("line_hen_rises", 32'(rise_n), 32'd3);
    chk("line_hen_rise_at_184", 32'(rise_bad), 32'd0);

    sm_hen_exp = 8'b0111_1000;
    chk("small_hen_pattern", 32'(sm_hen),    32'(sm_hen_exp));
    chk("small_fs_count",    32'(sm_fs),     32'd3);
    chk("small_fs_period40", 32'(sm_fs_off), 32'd0);
    chk("small_ven_lines23", 32'(sm_ven_f0), 32'd16);

    chk("pol_hs_low_frame",  32'(pol_hs_lo),    32'd36);
    chk("pol_vs_low_frame",  32'(pol_vs_lo),    32'd38);
    chk("pol_act_rises",     32'(pol_act_rise), 32'd5);
    chk("pol_fs_two_frames", 32'(pol_fs),       32'd2);

    // Random reset pulses at arbitrary raster positions.
    repeat (20) begin
      repeat ($urandom_range(1, 600)) @(negedge pclk);
      rstn = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge pclk);
      rstn = 1'b1;
    end

    // Directed one-cycle reset mid-frame.
    repeat (777) @(negedge pclk);
    rstn = 1'b0;
    @(negedge pclk);
    chk("mid_rst_hcnt", 32'(hc_w[0]),  32'd1039);
    chk("mid_rst_vcnt", 32'(vc_w[0]),  32'd665);
    chk("mid_rst_hen",  32'(hen_w[0]), 32'd0);
    chk("mid_rst_px",   32'(px_w[0]),  32'd0);
    chk("mid_rst_ls",   32'(ls_w[0]),  32'd0);
    chk("mid_rst_fs",   32'(fs_w[0]),  32'd0);
    rstn = 1'b1;
    @(negedge pclk);
    chk("mid_rel_fs",       32'(fs_w[0]), 32'd1);
    chk("mid_rel_hcnt",     32'(hc_w[0]), 32'd0);
    chk("mid_rel_small_fs", 32'(fs_w[1]), 32'd1);
    chk("mid_rel_pol_fs",   32'(fs_w[2]), 32'd1);

    def_early_hen = 0;
    for (int c = 0; c < 184; c++) begin
      if (hen_w[0]) def_early_hen++;
      @(negedge pclk);
    end
    chk("mid_no_stray_hen", 32'(def_early_hen), 32'd0);

    repeat (200) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
